// File: rtl/ana_stk_pkg.sv
// ana_stk_pkg
//   Shared definitions for the digital-to-analog stick emulator:
//   the sweep FSM state encoding, the hold-counter width and the
//   default values of every tunable parameter.
package ana_stk_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   // Width of the per-axis saturating hold counter (saturates at 15).
   localparam int HCW = 4;

   localparam int NCH_DEF   = 4;
   localparam int W_DEF     = 8;
   localparam int LIM_DEF   = 120;
   localparam int DSLOW_DEF = 15;
   localparam int DFAST_DEF = 30;
   localparam int ACCT_DEF  = 4;
   localparam int DECAY_DEF = 15;

endpackage

// File: rtl/ana_axis_step.sv
// ana_axis_step
//   Combinational next-state function for one emulated axis.
//   Given the current accumulator and hold count plus the sampled
//   PLUS/MINUS/HOLD bits it produces the updated accumulator (with
//   acceleration, self-centring decay and clamping) and hold count.
// Ports
//   acc       in  : current signed accumulator (W+2 bits)
//   hcnt      in  : current hold count
//   plus      in  : increase request
//   minus     in  : decrease request
//   hold      in  : 1 = keep position when released, 0 = decay to centre
//   acc_next  out : accumulator after this tick
//   hcnt_next out : hold count after this tick
module ana_axis_step
   import ana_stk_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int LIM   = LIM_DEF,
   parameter int DSLOW = DSLOW_DEF,
   parameter int DFAST = DFAST_DEF,
   parameter int ACCT  = ACCT_DEF,
   parameter int DECAY = DECAY_DEF
) (
   input  logic signed [W+1:0]  acc,
   input  logic [HCW-1:0]       hcnt,
   input  logic                 plus,
   input  logic                 minus,
   input  logic                 hold,
   output logic signed [W+1:0]  acc_next,
   output logic [HCW-1:0]       hcnt_next
);

   localparam logic [HCW-1:0] ACCT_C = HCW'(ACCT);
   localparam logic [HCW-1:0] HC_SAT = '1;

   // Arithmetic is done at 32 bits so that step + LIM can never wrap
   // before the clamp brings it back into range.
   logic signed [31:0] cur;
   logic signed [31:0] step;
   logic signed [31:0] sum;
   logic               one_dir;
   logic               opposite;

   always_comb begin
      cur       = {{(30-W){acc[W+1]}}, acc};
      one_dir   = plus ^ minus;
      // Pressing against the current deflection restarts acceleration.
      opposite  = (plus && (cur < 0)) || (minus && (cur > 0));
      step      = '0;
      sum       = cur;
      hcnt_next = hcnt;

      if (one_dir) begin
         if (opposite) begin
            step      = DSLOW;
            hcnt_next = '0;
         end else begin
            step      = (hcnt < ACCT_C) ? DSLOW : DFAST;
            hcnt_next = (hcnt == HC_SAT) ? hcnt : hcnt + 1'b1;
         end
         sum = plus ? (cur + step) : (cur - step);
      end else begin
         hcnt_next = '0;
         if (!hold) begin
            // Snap to zero inside the decay band so centring never overshoots.
            if (cur > DECAY)
               sum = cur - DECAY;
            else if (cur < -DECAY)
               sum = cur + DECAY;
            else
               sum = '0;
         end
      end

      if (sum > LIM)
         sum = LIM;
      else if (sum < -LIM)
         sum = -LIM;

      acc_next = sum[W+1:0];
   end

endmodule

// File: rtl/digi_ana_stick.sv
// digi_ana_stick
//   Emulates NCH analog stick axes from digital direction buttons.
//   A TICK strobe launches a sweep in which one shared step unit
//   updates one axis per cycle. Each axis output is either the real
//   analog input (SEL=1) or CENTER + accumulator, registered every cycle.
// Ports
//   CLK     in  : clock, rising edge
//   RESET_N in  : asynchronous active-low reset
//   TICK    in  : one-cycle update strobe
//   PLUS    in  : per-axis increase request     [NCH]
//   MINUS   in  : per-axis decrease request     [NCH]
//   HOLD    in  : per-axis hold-on-release      [NCH]
//   SEL     in  : per-axis analog pass-through  [NCH]
//   ANA_IN  in  : real analog values, axis k at [k*W +: W]
//   AXIS    out : registered axis values, same packing
//   BUSY    out : high while a sweep is in progress
module digi_ana_stick
   import ana_stk_pkg::*;
#(
   parameter int NCH    = NCH_DEF,
   parameter int W      = W_DEF,
   parameter int LIM    = LIM_DEF,
   parameter int DSLOW  = DSLOW_DEF,
   parameter int DFAST  = DFAST_DEF,
   parameter int ACCT   = ACCT_DEF,
   parameter int DECAY  = DECAY_DEF,
   parameter int CENTER = 2**(W-1)-1
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             TICK,
   input  logic [NCH-1:0]   PLUS,
   input  logic [NCH-1:0]   MINUS,
   input  logic [NCH-1:0]   HOLD,
   input  logic [NCH-1:0]   SEL,
   input  logic [NCH*W-1:0] ANA_IN,
   output logic [NCH*W-1:0] AXIS,
   output logic             BUSY
);

   localparam int             IW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0]  LAST = IW'(NCH-1);

   state_t          state_reg, state_next;
   logic [IW-1:0]   index_reg, index_next;
   logic            pending_reg, pending_next;
   logic            upd;

   logic signed [W+1:0] acc_arr  [NCH];
   logic [HCW-1:0]      hcnt_arr [NCH];
   logic signed [W+1:0] step_acc;
   logic [HCW-1:0]      step_hcnt;

   // ---------------- sweep FSM: state register ----------------
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg   <= IDLE;
         index_reg   <= '0;
         pending_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         index_reg   <= index_next;
         pending_reg <= pending_next;
      end
   end

   // ---------------- sweep FSM: next state ----------------
   always_comb begin
      state_next   = state_reg;
      index_next   = index_reg;
      pending_next = pending_reg;
      case (state_reg)
         IDLE: begin
            if (TICK) begin
               state_next = SWEEP;
               index_next = '0;
            end
         end
         SWEEP: begin
            // A second tick during a sweep is remembered once; extra ones are lost.
            if (TICK)
               pending_next = 1'b1;
            if (index_reg == LAST) begin
               index_next = '0;
               // A tick seen on the final cycle counts as pending too, so the
               // follow-up sweep starts back-to-back without an idle gap.
               if (pending_reg || TICK) begin
                  state_next   = SWEEP;
                  pending_next = 1'b0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               index_next = index_reg + 1'b1;
            end
         end
         default: begin
            state_next   = IDLE;
            index_next   = '0;
            pending_next = 1'b0;
         end
      endcase
   end

   // ---------------- sweep FSM: outputs ----------------
   always_comb begin
      upd  = (state_reg == SWEEP);
      BUSY = (state_reg == SWEEP);
   end

   // Shared step unit, fed with the axis selected by the sweep index.
   ana_axis_step #(
      .W     (W),
      .LIM   (LIM),
      .DSLOW (DSLOW),
      .DFAST (DFAST),
      .ACCT  (ACCT),
      .DECAY (DECAY)
   ) u_step (
      .acc       (acc_arr[index_reg]),
      .hcnt      (hcnt_arr[index_reg]),
      .plus      (PLUS[index_reg]),
      .minus     (MINUS[index_reg]),
      .hold      (HOLD[index_reg]),
      .acc_next  (step_acc),
      .hcnt_next (step_hcnt)
   );

   // ---------------- per-axis state and output registers ----------------
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_axis
         logic signed [W+1:0] acc_reg;
         logic [HCW-1:0]      hcnt_reg;
         logic [W-1:0]        axis_reg;
         logic signed [31:0]  acc_ext;
         logic [W-1:0]        dig;

         assign acc_ext = {{(30-W){acc_reg[W+1]}}, acc_reg};
         // Truncation to W bits is intentional; the clamp keeps it in range.
         assign dig     = W'(acc_ext + CENTER);

         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
               acc_reg  <= '0;
               hcnt_reg <= '0;
               axis_reg <= W'(CENTER);
            end else begin
               // Accumulator keeps tracking even while passed through, so
               // releasing SEL resumes from the emulated position.
               if (upd && (index_reg == IW'(gi))) begin
                  acc_reg  <= step_acc;
                  hcnt_reg <= step_hcnt;
               end
               axis_reg <= SEL[gi] ? ANA_IN[gi*W +: W] : dig;
            end
         end

         assign acc_arr[gi]      = acc_reg;
         assign hcnt_arr[gi]     = hcnt_reg;
         assign AXIS[gi*W +: W]  = axis_reg;
      end
   endgenerate

endmodule

// File: tb/tb_digi_ana_stick.sv
module tb_digi_ana_stick;

   localparam int NCH = 4;
   localparam int W   = 8;
   localparam int LIM = 120;
   localparam int DSLOW = 15;
   localparam int DFAST = 30;
   localparam int ACCT  = 4;
   localparam int DECAY = 15;
   localparam int CENTER = 127;

   logic             CLK = 1'b0;
   logic             RESET_N;
   logic             TICK;
   logic [NCH-1:0]   PLUS, MINUS, HOLD, SEL;
   logic [NCH*W-1:0] ANA_IN;
   logic [NCH*W-1:0] AXIS;
   logic             BUSY;

   // second, single-axis instance with a 20-count slow step
   logic       b_tick;
   logic [0:0] b_plus, b_minus, b_hold, b_sel;
   logic [7:0] b_ana, b_axis;
   logic       b_busy;

   int checks = 0;
   int errors = 0;

   int m_acc [NCH];
   int m_cnt [NCH];

   always #5 CLK = ~CLK;

   digi_ana_stick dut (
      .CLK(CLK), .RESET_N(RESET_N), .TICK(TICK), .PLUS(PLUS), .MINUS(MINUS),
      .HOLD(HOLD), .SEL(SEL), .ANA_IN(ANA_IN), .AXIS(AXIS), .BUSY(BUSY)
   );

   digi_ana_stick #(.NCH(1), .DSLOW(20)) dut_b (
      .CLK(CLK), .RESET_N(RESET_N), .TICK(b_tick), .PLUS(b_plus), .MINUS(b_minus),
      .HOLD(b_hold), .SEL(b_sel), .ANA_IN(b_ana), .AXIS(b_axis), .BUSY(b_busy)
   );

   typedef struct {
      logic p;
      logic m;
      logic h;
      int   exp0;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Reference model: one tick moves every axis by the rules of the stick.
   function automatic void model_tick(input int k, input bit p, input bit m, input bit h);
      int dir;
      int step;
      int mag;
      dir = (p && !m) ? 1 : ((m && !p) ? -1 : 0);
      if (dir != 0) begin
         if (dir * m_acc[k] < 0) begin
            step = DSLOW;
            m_cnt[k] = 0;
         end else begin
            step = (m_cnt[k] >= ACCT) ? DFAST : DSLOW;
            m_cnt[k] = (m_cnt[k] + 1 > 15) ? 15 : m_cnt[k] + 1;
         end
         m_acc[k] = m_acc[k] + dir * step;
      end else begin
         m_cnt[k] = 0;
         if (!h) begin
            mag = (m_acc[k] < 0) ? -m_acc[k] : m_acc[k];
            if (mag <= DECAY) m_acc[k] = 0;
            else m_acc[k] = (m_acc[k] > 0) ? m_acc[k] - DECAY : m_acc[k] + DECAY;
         end
      end
      if (m_acc[k] > LIM) m_acc[k] = LIM;
      if (m_acc[k] < -LIM) m_acc[k] = -LIM;
   endfunction

   function automatic void model_sweep();
      for (int k = 0; k < NCH; k++) model_tick(k, PLUS[k], MINUS[k], HOLD[k]);
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_acc[k] = 0;
         m_cnt[k] = 0;
      end
   endfunction

   function automatic int exp_lane(input int k);
      if (SEL[k]) return int'(ANA_IN[k*W +: W]);
      return (CENTER + m_acc[k]) & 255;
   endfunction

   function automatic int lane(input int k);
      return int'(AXIS[k*W +: W]);
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while (BUSY && n < 40) begin
         @(negedge CLK);
         n++;
      end
      check("busy_timeout", int'(BUSY), 0);
      @(negedge CLK);
   endtask

   task automatic pulse_tick();
      @(negedge CLK);
      TICK = 1'b1;
      @(negedge CLK);
      TICK = 1'b0;
      wait_idle();
      model_sweep();
      $display("tick plus=%b minus=%b hold=%b sel=%b axis=%h", PLUS, MINUS, HOLD, SEL, AXIS);
   endtask

   task automatic compare_all(input string nm);
      for (int k = 0; k < NCH; k++) check($sformatf("%s_lane%0d", nm, k), lane(k), exp_lane(k));
   endtask

   task automatic pulse_tick_b();
      int n;
      @(negedge CLK);
      b_tick = 1'b1;
      @(negedge CLK);
      b_tick = 1'b0;
      n = 0;
      while (b_busy && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check("b_busy_timeout", int'(b_busy), 0);
      @(negedge CLK);
      $display("tick_b plus=%b hold=%b axis=%0d", b_plus, b_hold, b_axis);
   endtask

   initial begin
      int busy_cnt;

      RESET_N = 1'b0; TICK = 1'b0;
      PLUS = '0; MINUS = '0; HOLD = '0; SEL = '0; ANA_IN = '0;
      b_tick = 1'b0; b_plus = '0; b_minus = '0; b_hold = '0; b_sel = '0; b_ana = '0;
      model_reset();

      // table: PLUS[0] held 10 ticks, then released with HOLD=0
      for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 0};
      tbl[0].exp0 = 142; tbl[1].exp0 = 157; tbl[2].exp0 = 172; tbl[3].exp0 = 187;
      tbl[4].exp0 = 217;
      for (int i = 5; i < 10; i++) tbl[i].exp0 = 247;
      for (int i = 10; i < 19; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 0};
      tbl[10].exp0 = 232; tbl[11].exp0 = 217; tbl[12].exp0 = 202; tbl[13].exp0 = 187;
      tbl[14].exp0 = 172; tbl[15].exp0 = 157; tbl[16].exp0 = 142; tbl[17].exp0 = 127;
      tbl[18].exp0 = 127;

      // reset state
      repeat (3) @(negedge CLK);
      check("reset_busy", int'(BUSY), 0);
      for (int k = 0; k < NCH; k++) check($sformatf("reset_lane%0d", k), lane(k), CENTER);
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLK);

      // acceleration, saturation and decay on axis 0
      for (int i = 0; i < 19; i++) begin
         PLUS[0] = tbl[i].p; MINUS[0] = tbl[i].m; HOLD[0] = tbl[i].h;
         pulse_tick();
         check($sformatf("table_row%0d", i), lane(0), tbl[i].exp0);
      end
      compare_all("after_table");

      // both pressed with HOLD=1 at -45: position kept and hold count cleared
      PLUS = '0; MINUS = 4'b0001; HOLD = '0;
      repeat (3) pulse_tick();
      check("minus3", lane(0), 82);
      PLUS = 4'b0001; MINUS = 4'b0001; HOLD = 4'b0001;
      pulse_tick();
      check("both_hold_a", lane(0), 82);
      pulse_tick();
      check("both_hold_b", lane(0), 82);
      PLUS = '0; MINUS = 4'b0001; HOLD = '0;
      pulse_tick();
      check("after_both_1", lane(0), 67);
      pulse_tick();
      check("after_both_2", lane(0), 52);

      // two back-to-back ticks: two full sweeps, BUSY high 2*NCH cycles
      PLUS = 4'b0101; MINUS = 4'b0010; HOLD = 4'b1000; SEL = '0;
      @(negedge CLK);
      TICK = 1'b1;
      @(negedge CLK);
      busy_cnt = int'(BUSY);
      @(negedge CLK);
      TICK = 1'b0;
      busy_cnt += int'(BUSY);
      repeat (18) begin
         @(negedge CLK);
         busy_cnt += int'(BUSY);
      end
      model_sweep();
      model_sweep();
      $display("double_tick busy_cycles=%0d axis=%h", busy_cnt, AXIS);
      check("double_tick_busy", busy_cnt, 2 * NCH);
      compare_all("double_tick");

      // random stimulus against the model, including pass-through lanes
      for (int it = 0; it < 40; it++) begin
         PLUS   = NCH'($urandom);
         MINUS  = NCH'($urandom);
         HOLD   = NCH'($urandom);
         SEL    = NCH'($urandom);
         ANA_IN = $urandom;
         pulse_tick();
         compare_all($sformatf("rand%0d", it));
      end

      // releasing SEL shows the accumulator that kept tracking
      SEL = '0;
      repeat (2) @(negedge CLK);
      compare_all("sel_release");

      // reset asserted mid-sweep at index 2
      PLUS = 4'b0001; MINUS = '0; HOLD = '0; SEL = '0;
      @(negedge CLK);
      TICK = 1'b1;
      @(negedge CLK);
      TICK = 1'b0;
      repeat (2) @(negedge CLK);
      check("pre_reset_busy", int'(BUSY), 1);
      RESET_N = 1'b0;
      #1;
      model_reset();
      check("midreset_busy", int'(BUSY), 0);
      for (int k = 0; k < NCH; k++) check($sformatf("midreset_lane%0d", k), lane(k), CENTER);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
      pulse_tick();
      check("post_reset_lane0", lane(0), 142);
      compare_all("post_reset");

      // no overshoot from +20 with DECAY 15 (second instance, DSLOW 20)
      b_plus = 1'b1; b_hold = 1'b0;
      pulse_tick_b();
      check("b_plus20", int'(b_axis), 147);
      b_plus = 1'b0;
      pulse_tick_b();
      check("b_decay1", int'(b_axis), 132);
      pulse_tick_b();
      check("b_decay2", int'(b_axis), 127);
      pulse_tick_b();
      check("b_decay3", int'(b_axis), 127);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/digi_ana_stick.md
DIGI_ANA_STICK -- requirements
Module: digi_ana_stick

Interface
REQ-001 The block SHALL provide parameter NCH, default 4, giving the number of independent axes (two sticks times X/Y).
REQ-002 The block SHALL provide parameter W, default 8, giving the output axis width in bits.
REQ-003 The block SHALL provide parameter LIM, default 120, giving the maximum absolute deflection; LIM SHALL be at most 2^(W-1)-1.
REQ-004 The block SHALL provide parameter DSLOW, default 15, giving the step added per tick while the hold count is below ACCT.
REQ-005 The block SHALL provide parameter DFAST, default 30, giving the step added per tick once the hold count reaches ACCT.
REQ-006 The block SHALL provide parameter ACCT, default 4, giving the number of consecutive held ticks before the fast step applies (range 1..15).
REQ-007 The block SHALL provide parameter DECAY, default 15, giving the return-to-centre step per tick when no direction is held.
REQ-008 The block SHALL provide parameter CENTER, default 2^(W-1)-1, giving the output code for zero deflection.
REQ-009 Port CLK, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-010 Port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-011 Port TICK, input, 1 bit: a one-cycle update strobe (for example, once per frame).
REQ-012 Port PLUS, input, NCH bits: digital increase request per axis.
REQ-013 Port MINUS, input, NCH bits: digital decrease request per axis.
REQ-014 Port HOLD, input, NCH bits: per axis, 1 = hold position when released, 0 = self-centring.
REQ-015 Port SEL, input, NCH bits: per axis, 1 = pass ANA_IN through, 0 = use the digital emulation.
REQ-016 Port ANA_IN, input, NCH*W bits: the real analog value per axis; axis k occupies bits [k*W +: W].
REQ-017 Port AXIS, output, NCH*W bits: the registered axis outputs, using the same packing as ANA_IN.
REQ-018 Port BUSY, output, 1 bit: high while an update sweep is in progress.

Function
REQ-019 A single shared step unit SHALL update the axes in sequence, one axis per cycle; the FSM states SHALL be IDLE and SWEEP.
REQ-020 In IDLE with TICK=1, the FSM SHALL go to SWEEP with index 0 on the next cycle.
REQ-021 In SWEEP, the FSM SHALL update the axis at the current index and increment the index; after axis NCH-1 it SHALL return to IDLE.
REQ-022 BUSY SHALL equal (state==SWEEP).
REQ-023 A TICK received while in SWEEP SHALL set a pending flag; on return to IDLE, a set flag SHALL start a new sweep immediately and clear itself.
REQ-024 Further TICKs while the pending flag is already set SHALL be dropped.
REQ-025 PLUS, MINUS and HOLD for an axis SHALL be sampled in the cycle that axis is updated.
REQ-026 Each axis SHALL keep a signed accumulator of W+2 bits and a 4-bit saturating hold counter.
REQ-027 If exactly one of PLUS or MINUS is set, the step SHALL be DSLOW when the hold count is below ACCT and DFAST otherwise; the accumulator SHALL add (PLUS) or subtract (MINUS) the step, and the hold count SHALL increment and saturate at 15.
REQ-028 If the pressed direction is opposite to the accumulator sign, the hold count SHALL reset to 0 and the slow step SHALL be used.
REQ-029 If neither or both of PLUS and MINUS are set, the hold count SHALL be cleared.
REQ-030 With neither or both set and HOLD=1, the accumulator SHALL be unchanged.
REQ-031 With neither or both set and HOLD=0, the accumulator SHALL move DECAY toward 0; if its absolute value is at most DECAY it SHALL become exactly 0, with no overshoot or oscillation.
REQ-032 After each step the accumulator SHALL be clamped to [-LIM, +LIM].
REQ-033 The digital value SHALL be CENTER + accumulator, truncated to W bits.
REQ-034 AXIS[k] SHALL be registered with one cycle of latency: ANA_IN[k] when SEL[k]=1, otherwise the digital value; it SHALL refresh every cycle.
REQ-035 The accumulator of an axis SHALL keep being updated while SEL[k]=1, so that switching SEL produces no jump beyond the current digital state.

Reset
REQ-036 When RESET_N=0, the block SHALL asynchronously clear all accumulators, hold counts, the index and the pending flag, and enter IDLE.
REQ-037 When RESET_N=0, BUSY SHALL be 0 and every AXIS lane SHALL be CENTER.
REQ-038 Reset asserted mid-sweep SHALL abort the sweep without updating the remaining axes.
REQ-039 The first TICK after RESET_N rises SHALL start a normal sweep.

Structure
REQ-040 A package ana_stk_pkg SHALL hold the FSM state enum, the hold-count width (4) and the default parameter constants.
REQ-041 A combinational sub-module ana_axis_step SHALL implement the step, decay, clamp and acceleration for one axis; digi_ana_stick SHALL instantiate it once.

Verification
REQ-042 Bench scenario: defaults, PLUS[0] held for 10 ticks -> AXIS[0] = 142, 157, 172, 187, 217, 247, then saturates at 247 (LIM 120).
REQ-043 Bench scenario: from deflection +120, release with HOLD=0 -> AXIS decays by 15 per tick to 127 in 8 ticks and stays at 127.
REQ-044 Bench scenario: deflection +20 with DECAY=15, release -> 132 then 127, with no negative overshoot.
REQ-045 Bench scenario: TICK pulsed on two consecutive cycles -> BUSY stays high for 2*NCH cycles, and exactly two steps are applied per axis.
REQ-046 Bench scenario: PLUS and MINUS both held, HOLD=1, at deflection -45 -> AXIS stays 82 and the hold count is 0.
REQ-047 Bench scenario: RESET_N pulsed low during SWEEP at index 2 -> all AXIS lanes read 127 immediately, BUSY=0, and the next TICK gives AXIS[0] = 142 with PLUS[0] set.
